i2c_reg_slave: RTL

- I2C slave register target; sits directly downstream of the team's I2C master on the shared scl/sda wires.
- Oversamples scl/sda on the system clock and decodes the master's transaction format:
  - write: S, {addr,W}, reg, data, P
  - read: S, {addr,R}, reg, Sr, {addr,R}, data-out, NACK, P
- Holds a small byte-wide register file and reports every write on a one-cycle strobe.

---
 rtl/i2c_reg_slave.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_slave.sv
// I2C slave register target: oversamples scl/sda, decodes
//   write: S {addr,W} reg data... P
//   read : S {addr,R} reg Sr {addr,R} data... NACK P
// and holds a REG_DEPTH x 8 register file, pulsing wr_strobe on each
// committed byte.
// Optional: define I2C_SLAVE_AUTOINC_EN to advance the register pointer
// after every data ACK (write or read), wrapping at REG_DEPTH.
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         REG_DEPTH  = 16,
    parameter int         AW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    inout  wire           sda,
    output logic          busy,
    output logic          addr_match,
    output logic          wr_strobe,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

`ifdef I2C_SLAVE_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WAIT_SR,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t state, nxt;

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_d, sda_d;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg, tx;
    logic          rw, sr_seen, ack_drv, rd_drv, sda_oe;
    logic [AW-1:0] ptr;
    logic [7:0]    regs [REG_DEPTH];

    // synchronized levels and the one-flop history used for edge detection
    wire scl_s     = scl_sync[1];
    wire sda_s     = sda_sync[1];
    wire scl_rise  = scl_s & ~scl_d;
    wire scl_fall  = ~scl_s & scl_d;
    wire bus_start = scl_s & scl_d & sda_d & ~sda_s;
    wire bus_stop  = scl_s & scl_d & ~sda_d & sda_s;

    wire [7:0] byte_nxt  = {shreg[6:0], sda_s};
    wire       byte_done = scl_rise && (bit_cnt == 4'd7);
    wire       addr_hit  = (byte_nxt[7:1] == SLAVE_ADDR);
    wire       reg_ok    = (32'(byte_nxt) < REG_DEPTH);
    // ACK phases: first falling edge starts the low drive, the second ends it
    wire       in_ack    = (state == ADDR_ACK) || (state == REG_ACK) || (state == WDATA_ACK);
    wire       ack_end   = in_ack && scl_fall && ack_drv;

    // two-flop synchronizer plus edge history; idle bus reads high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // next state; bus conditions pre-empt whatever state we are in
    always_comb begin
        nxt = state;
        if (bus_stop)       nxt = IDLE;
        else if (bus_start) nxt = ADDR;
        else begin
            case (state)
                ADDR:      if (byte_done) nxt = addr_hit ? ADDR_ACK : IDLE;
                ADDR_ACK:  if (ack_end)   nxt = (rw && sr_seen) ? RDATA : REG;
                REG:       if (byte_done) nxt = reg_ok ? REG_ACK : IDLE;
                REG_ACK:   if (ack_end)   nxt = rw ? WAIT_SR : WDATA;
                WDATA:     if (byte_done) nxt = WDATA_ACK;
                WDATA_ACK: if (ack_end)   nxt = WDATA;
                RDATA:     if (scl_rise && rd_drv && bit_cnt == 4'd7) nxt = RDATA_ACK;
                RDATA_ACK: if (scl_rise && !rd_drv) nxt = sda_s ? WAIT_STOP : RDATA;
                default:   nxt = state;
            endcase
        end
    end

    // open-drain output: low during an ACK or for a 0 data bit, else released
    always_comb begin
        sda_oe = ack_drv | (rd_drv & ~tx[7]);
    end

    assign sda = sda_oe ? 1'b0 : 1'bz;

    // datapath: bit shifting, pointer, register file, write strobe, status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            tx         <= '0;
            rw         <= 1'b0;
            sr_seen    <= 1'b0;
            ack_drv    <= 1'b0;
            rd_drv     <= 1'b0;
            ptr        <= '0;
            busy       <= 1'b0;
            addr_match <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (bus_stop) begin
                bit_cnt    <= '0;
                ack_drv    <= 1'b0;
                rd_drv     <= 1'b0;
                sr_seen    <= 1'b0;
                busy       <= 1'b0;
                addr_match <= 1'b0;
            end else if (bus_start) begin
                bit_cnt <= '0;
                ack_drv <= 1'b0;
                rd_drv  <= 1'b0;
            end else begin
                case (state)
                    ADDR, REG, WDATA: begin
                        if (scl_rise) begin
                            shreg   <= byte_nxt;
                            bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                        end
                        if (byte_done && state == ADDR) begin
                            addr_match <= addr_hit;
                            if (addr_hit) begin
                                busy <= 1'b1;
                                rw   <= byte_nxt[0];
                            end
                        end
                        if (byte_done && state == REG && reg_ok)
                            ptr <= byte_nxt[AW-1:0];
                        if (byte_done && state == WDATA) begin
                            regs[ptr] <= byte_nxt;
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= byte_nxt;
                            if (AUTOINC) ptr <= ptr + 1'b1;
                        end
                    end
                    ADDR_ACK, REG_ACK, WDATA_ACK: begin
                        if (scl_fall) ack_drv <= ~ack_drv;
                        // the falling edge that ends the address ACK launches read bit 7
                        if (ack_end && state == ADDR_ACK && rw && sr_seen) begin
                            tx      <= regs[ptr];
                            rd_drv  <= 1'b1;
                            bit_cnt <= '0;
                        end
                        if (ack_end && state == REG_ACK && rw) sr_seen <= 1'b1;
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (!rd_drv) begin
                                tx     <= regs[ptr];
                                rd_drv <= 1'b1;
                            end else begin
                                tx <= {tx[6:0], 1'b0};
                            end
                        end
                        if (scl_rise && rd_drv)
                            bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                    end
                    RDATA_ACK: begin
                        if (scl_fall) rd_drv <= 1'b0;
                        if (scl_rise && !rd_drv && !sda_s && AUTOINC) ptr <= ptr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
